mcontrol_mc: RTL and testbench

Parametrised multi-channel successor to the blitter memory-cycle controller. It arbitrates NCH requesters (blitter read/write ports, and future DMA/GPU ports) onto the single Tom memory bus using round-robin. It drives mreq/read/width/address with tri-state enables gated by bus ownership. Unlike the single-channel block, it allows up to OUTST reads to be awaiting data, and steers each in-order data acknowledge back to the channel that issued that read.

---
 rtl/mcontrol_mc.sv | 223 ++++++++++++++++++++++
 tb/tb_mcontrol_mc.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcontrol_mc.sv
// Multi-channel round-robin memory-cycle controller for the Tom bus.
// Tracks up to OUTST reads awaiting data and routes in-order data acks back to their issuers.
module mcontrol_mc #(
  parameter  int NCH   = 2,
  parameter  int AW    = 24,
  parameter  int OUTST = 2,
  localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NCH-1:0]    req_rd,
  input  logic [NCH-1:0]    req_wr,
  input  logic [NCH*AW-1:0] req_addr,
  input  logic [NCH*4-1:0]  req_width,
  input  logic [NCH-1:0]    req_justify,
  input  logic              bus_back,
  input  logic              ack,
  input  logic              dack,
  output logic              mreq_out,
  output logic              read_out,
  output logic              justify_out,
  output logic [3:0]        width_out,
  output logic [AW-1:0]     addr_out,
  output logic              bus_oe,
  output logic              active,
  output logic              memidle,
  output logic [NCH-1:0]    gnt_ack,
  output logic [NCH-1:0]    rdata_ack,
  output logic [CW-1:0]     cur_ch,
  output logic              outst_full
);

  localparam int CNTW = $clog2(OUTST + 1);
  localparam int PW   = (OUTST > 1) ? $clog2(OUTST) : 1;
  localparam logic [CNTW-1:0] OUTST_C = CNTW'(OUTST);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  state_t          state_r, state_next_s;
  logic            mreq_r, read_r, justify_r;
  logic [3:0]      width_r;
  logic [AW-1:0]   addr_r;
  logic [CW-1:0]   cur_ch_r, rr_ptr_r;
  logic [CW-1:0]   fifo_r [OUTST];
  logic [PW-1:0]   wr_ptr_r, rd_ptr_r;
  logic [CNTW-1:0] count_r, count_next_s;

  logic            accept_s, push_s, pop_s, full_next_s;
  logic [NCH-1:0]  elig_s;
  logic            sel_valid_s, sel_rd_s, load_s;
  logic [CW-1:0]   sel_ch_s, rr_next_s;
  logic [CW:0]     sel_idx_s, rr_sum_s;

  logic [AW-1:0]   addr_a [NCH];
  logic [3:0]      width_a [NCH];

  for (genvar g = 0; g < NCH; g++) begin : g_unpack
    assign addr_a[g]  = req_addr[g*AW +: AW];
    assign width_a[g] = req_width[g*4 +: 4];
  end

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(OUTST - 1)) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1);
    end
  endfunction

  assign active   = (state_r == ST_ACTIVE);
  assign accept_s = active & ack & bus_back;
  assign push_s   = accept_s & read_r;
  assign pop_s    = dack & (count_r != CNTW'(0));

  // FIFO occupancy after this cycle's push/pop; arbitration sees this value
  always_comb begin
    count_next_s = count_r;
    if (push_s && !pop_s) begin
      count_next_s = count_r + CNTW'(1);
    end else if (pop_s && !push_s) begin
      count_next_s = count_r - CNTW'(1);
    end else begin
      count_next_s = count_r;
    end
  end

  assign full_next_s = (count_next_s == OUTST_C);
  assign elig_s      = req_wr | (req_rd & {NCH{~full_next_s}});

  // Round-robin search starting at the pointer, wrapping at NCH
  always_comb begin
    sel_valid_s = 1'b0;
    sel_ch_s    = rr_ptr_r;
    sel_idx_s   = {(CW+1){1'b0}};
    for (int k = 0; k < NCH; k++) begin
      sel_idx_s = {1'b0, rr_ptr_r} + (CW+1)'(k);
      if (sel_idx_s >= (CW+1)'(NCH)) begin
        sel_idx_s = sel_idx_s - (CW+1)'(NCH);
      end else begin
        sel_idx_s = sel_idx_s;
      end
      if (!sel_valid_s && elig_s[sel_idx_s[CW-1:0]]) begin
        sel_valid_s = 1'b1;
        sel_ch_s    = sel_idx_s[CW-1:0];
      end else begin
        sel_valid_s = sel_valid_s;
      end
    end
  end

  // A full FIFO turns a combined rd/wr request into its write so the count cannot overflow
  assign sel_rd_s = req_rd[sel_ch_s] & ~full_next_s;
  assign load_s   = sel_valid_s & (~active | accept_s);

  // Pointer advance past the selected channel
  always_comb begin
    rr_sum_s = {1'b0, sel_ch_s} + (CW+1)'(1);
    if (rr_sum_s >= (CW+1)'(NCH)) begin
      rr_next_s = {CW{1'b0}};
    end else begin
      rr_next_s = rr_sum_s[CW-1:0];
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (sel_valid_s) begin
          state_next_s = ST_ACTIVE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (accept_s && !sel_valid_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_ACTIVE;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Bus output registers and arbitration pointer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mreq_r    <= 1'b0;
      read_r    <= 1'b0;
      justify_r <= 1'b0;
      width_r   <= 4'h0;
      addr_r    <= {AW{1'b0}};
      cur_ch_r  <= {CW{1'b0}};
      rr_ptr_r  <= {CW{1'b0}};
    end else begin
      mreq_r <= (state_next_s == ST_ACTIVE);
      if (load_s) begin
        read_r    <= sel_rd_s;
        justify_r <= req_justify[sel_ch_s];
        width_r   <= width_a[sel_ch_s];
        addr_r    <= addr_a[sel_ch_s];
        cur_ch_r  <= sel_ch_s;
        rr_ptr_r  <= rr_next_s;
      end
    end
  end

  // Outstanding-read FIFO of issuing channel numbers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < OUTST; i++) begin
        fifo_r[i] <= {CW{1'b0}};
      end
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CNTW{1'b0}};
    end else begin
      if (push_s) begin
        fifo_r[wr_ptr_r] <= cur_ch_r;
        wr_ptr_r         <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      count_r <= count_next_s;
    end
  end

  // One-hot acknowledge steering
  always_comb begin
    gnt_ack   = {NCH{1'b0}};
    rdata_ack = {NCH{1'b0}};
    for (int i = 0; i < NCH; i++) begin
      gnt_ack[i]   = accept_s & (cur_ch_r == CW'(i));
      rdata_ack[i] = pop_s & (fifo_r[rd_ptr_r] == CW'(i));
    end
  end

  assign mreq_out    = mreq_r;
  assign read_out    = read_r;
  assign justify_out = justify_r;
  assign width_out   = width_r;
  assign addr_out    = addr_r;
  assign cur_ch      = cur_ch_r;
  assign bus_oe      = bus_back;
  assign memidle     = ~active & (count_r == CNTW'(0));
  assign outst_full  = (count_r == OUTST_C);

endmodule

// File: tb/tb_mcontrol_mc.sv
// Directed self-checking bench for mcontrol_mc with NCH=2, AW=24, OUTST=2.
module tb_mcontrol_mc;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  req_rd, req_wr, req_justify;
  logic [47:0] req_addr;
  logic [7:0]  req_width;
  logic        bus_back, ack, dack;
  logic        mreq_out, read_out, justify_out, bus_oe, active, memidle, outst_full;
  logic [3:0]  width_out;
  logic [23:0] addr_out;
  logic [1:0]  gnt_ack, rdata_ack;
  logic [0:0]  cur_ch;

  int checks = 0;
  int errors = 0;

  mcontrol_mc #(.NCH(2), .AW(24), .OUTST(2)) dut (
    .clk(clk), .reset_n(reset_n), .req_rd(req_rd), .req_wr(req_wr),
    .req_addr(req_addr), .req_width(req_width), .req_justify(req_justify),
    .bus_back(bus_back), .ack(ack), .dack(dack),
    .mreq_out(mreq_out), .read_out(read_out), .justify_out(justify_out),
    .width_out(width_out), .addr_out(addr_out), .bus_oe(bus_oe),
    .active(active), .memidle(memidle), .gnt_ack(gnt_ack),
    .rdata_ack(rdata_ack), .cur_ch(cur_ch), .outst_full(outst_full)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; req_rd = 2'b00; req_wr = 2'b00; req_justify = 2'b00;
    req_addr = 48'h0; req_width = 8'h00; bus_back = 1'b1; ack = 1'b0; dack = 1'b0;
    tick; tick;
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL rst_active: got %b expected 0", active); end
    checks++; if (mreq_out !== 1'b0) begin errors++; $display("FAIL rst_mreq: got %b expected 0", mreq_out); end
    checks++; if (addr_out !== 24'h0) begin errors++; $display("FAIL rst_addr: got %h expected 0", addr_out); end
    checks++; if (width_out !== 4'h0) begin errors++; $display("FAIL rst_width: got %h expected 0", width_out); end
    checks++; if (memidle !== 1'b1) begin errors++; $display("FAIL rst_memidle: got %b expected 1", memidle); end
    checks++; if (outst_full !== 1'b0) begin errors++; $display("FAIL rst_full: got %b expected 0", outst_full); end
    checks++; if (gnt_ack !== 2'b00) begin errors++; $display("FAIL rst_gnt: got %b expected 00", gnt_ack); end
    reset_n = 1'b1;
    tick;
  endtask

  task automatic test_single_write;
    req_wr = 2'b01; req_addr[23:0] = 24'h123456; req_width[3:0] = 4'h8; req_justify = 2'b01;
    tick;
    req_wr = 2'b00;
    #1;
    checks++; if (mreq_out !== 1'b1) begin errors++; $display("FAIL sw_mreq: got %b expected 1", mreq_out); end
    checks++; if (addr_out !== 24'h123456) begin errors++; $display("FAIL sw_addr: got %h expected 123456", addr_out); end
    checks++; if (width_out !== 4'h8) begin errors++; $display("FAIL sw_width: got %h expected 8", width_out); end
    checks++; if (justify_out !== 1'b1) begin errors++; $display("FAIL sw_justify: got %b expected 1", justify_out); end
    checks++; if (read_out !== 1'b0) begin errors++; $display("FAIL sw_read: got %b expected 0", read_out); end
    checks++; if (gnt_ack !== 2'b00) begin errors++; $display("FAIL sw_gnt_c1: got %b expected 00", gnt_ack); end
    tick;
    checks++; if (gnt_ack !== 2'b00) begin errors++; $display("FAIL sw_gnt_c2: got %b expected 00", gnt_ack); end
    tick;
    ack = 1'b1;
    #1;
    checks++; if (gnt_ack !== 2'b01) begin errors++; $display("FAIL sw_gnt_c3: got %b expected 01", gnt_ack); end
    tick;
    ack = 1'b0;
    #1;
    checks++; if (gnt_ack !== 2'b00) begin errors++; $display("FAIL sw_gnt_after: got %b expected 00", gnt_ack); end
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL sw_idle: got %b expected 0", active); end
    checks++; if (memidle !== 1'b1) begin errors++; $display("FAIL sw_memidle: got %b expected 1", memidle); end
  endtask

  // The pointer sits at 1 after the single ch0 write, so ch1 wins first.
  task automatic test_back_to_back;
    logic [1:0]  exp_gnt [4];
    logic [23:0] exp_addr [4];
    exp_gnt[0] = 2'b10; exp_gnt[1] = 2'b01; exp_gnt[2] = 2'b10; exp_gnt[3] = 2'b01;
    exp_addr[0] = 24'h000200; exp_addr[1] = 24'h000100; exp_addr[2] = 24'h000200; exp_addr[3] = 24'h000100;
    req_addr = {24'h000200, 24'h000100}; req_wr = 2'b11; ack = 1'b1;
    tick;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) req_wr = 2'b00;
      #1;
      checks++; if (gnt_ack !== exp_gnt[i]) begin errors++; $display("FAIL b2b_gnt[%0d]: got %b expected %b", i, gnt_ack, exp_gnt[i]); end
      checks++; if (addr_out !== exp_addr[i]) begin errors++; $display("FAIL b2b_addr[%0d]: got %h expected %h", i, addr_out, exp_addr[i]); end
      checks++; if (active !== 1'b1) begin errors++; $display("FAIL b2b_active[%0d]: got %b expected 1", i, active); end
      tick;
    end
    ack = 1'b0;
    #1;
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b expected 0", active); end
  endtask

  task automatic test_outstanding;
    req_addr = {24'h0000FF, 24'hA00000}; req_rd = 2'b01; ack = 1'b1;
    tick;
    #1;
    checks++; if (gnt_ack !== 2'b01) begin errors++; $display("FAIL os_gnt1: got %b expected 01", gnt_ack); end
    checks++; if (read_out !== 1'b1) begin errors++; $display("FAIL os_read1: got %b expected 1", read_out); end
    tick;
    checks++; if (gnt_ack !== 2'b01) begin errors++; $display("FAIL os_gnt2: got %b expected 01", gnt_ack); end
    tick;
    for (int i = 0; i < 2; i++) begin
      checks++; if (active !== 1'b0) begin errors++; $display("FAIL os_held[%0d]: got %b expected 0", i, active); end
      checks++; if (outst_full !== 1'b1) begin errors++; $display("FAIL os_full[%0d]: got %b expected 1", i, outst_full); end
      checks++; if (gnt_ack !== 2'b00) begin errors++; $display("FAIL os_idle_gnt[%0d]: got %b expected 00", i, gnt_ack); end
      tick;
    end
    req_wr = 2'b10;
    tick;
    req_wr = 2'b00;
    #1;
    checks++; if (cur_ch !== 1'b1) begin errors++; $display("FAIL os_wr_ch: got %b expected 1", cur_ch); end
    checks++; if (read_out !== 1'b0) begin errors++; $display("FAIL os_wr_read: got %b expected 0", read_out); end
    checks++; if (gnt_ack !== 2'b10) begin errors++; $display("FAIL os_wr_gnt: got %b expected 10", gnt_ack); end
    tick;
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL os_wr_idle: got %b expected 0", active); end
    dack = 1'b1;
    #1;
    checks++; if (rdata_ack !== 2'b01) begin errors++; $display("FAIL os_rdata1: got %b expected 01", rdata_ack); end
    tick;
    dack = 1'b0; req_rd = 2'b00;
    #1;
    checks++; if (active !== 1'b1) begin errors++; $display("FAIL os_third_active: got %b expected 1", active); end
    checks++; if (read_out !== 1'b1) begin errors++; $display("FAIL os_third_read: got %b expected 1", read_out); end
    checks++; if (addr_out !== 24'hA00000) begin errors++; $display("FAIL os_third_addr: got %h expected a00000", addr_out); end
    checks++; if (outst_full !== 1'b0) begin errors++; $display("FAIL os_third_full: got %b expected 0", outst_full); end
    checks++; if (gnt_ack !== 2'b01) begin errors++; $display("FAIL os_third_gnt: got %b expected 01", gnt_ack); end
    tick;
    dack = 1'b1;
    #1;
    checks++; if (rdata_ack !== 2'b01) begin errors++; $display("FAIL os_drain1: got %b expected 01", rdata_ack); end
    tick;
    checks++; if (rdata_ack !== 2'b01) begin errors++; $display("FAIL os_drain2: got %b expected 01", rdata_ack); end
    tick;
    checks++; if (rdata_ack !== 2'b00) begin errors++; $display("FAIL os_empty_dack: got %b expected 00", rdata_ack); end
    checks++; if (memidle !== 1'b1) begin errors++; $display("FAIL os_memidle: got %b expected 1", memidle); end
    dack = 1'b0; ack = 1'b0;
  endtask

  task automatic test_interleave;
    req_rd = 2'b11;
    tick;
    ack = 1'b1; req_rd = 2'b01;
    #1;
    checks++; if (gnt_ack !== 2'b10) begin errors++; $display("FAIL il_gnt_ch1: got %b expected 10", gnt_ack); end
    tick;
    req_rd = 2'b00;
    #1;
    checks++; if (gnt_ack !== 2'b01) begin errors++; $display("FAIL il_gnt_ch0: got %b expected 01", gnt_ack); end
    tick;
    ack = 1'b0;
    #1;
    checks++; if (outst_full !== 1'b1) begin errors++; $display("FAIL il_full: got %b expected 1", outst_full); end
    dack = 1'b1;
    #1;
    checks++; if (rdata_ack !== 2'b10) begin errors++; $display("FAIL il_rdata1: got %b expected 10", rdata_ack); end
    tick;
    checks++; if (rdata_ack !== 2'b01) begin errors++; $display("FAIL il_rdata2: got %b expected 01", rdata_ack); end
    tick;
    dack = 1'b0;
    #1;
    checks++; if (memidle !== 1'b1) begin errors++; $display("FAIL il_memidle: got %b expected 1", memidle); end
  endtask

  task automatic test_push_pop;
    req_rd = 2'b01;
    tick;
    ack = 1'b1; req_rd = 2'b10;
    #1;
    checks++; if (gnt_ack !== 2'b01) begin errors++; $display("FAIL pp_gnt_ch0: got %b expected 01", gnt_ack); end
    tick;
    req_rd = 2'b00; dack = 1'b1;
    #1;
    checks++; if (gnt_ack !== 2'b10) begin errors++; $display("FAIL pp_gnt_ch1: got %b expected 10", gnt_ack); end
    checks++; if (rdata_ack !== 2'b01) begin errors++; $display("FAIL pp_rdata_ch0: got %b expected 01", rdata_ack); end
    tick;
    ack = 1'b0; dack = 1'b0;
    #1;
    checks++; if (outst_full !== 1'b0) begin errors++; $display("FAIL pp_full: got %b expected 0", outst_full); end
    checks++; if (memidle !== 1'b0) begin errors++; $display("FAIL pp_memidle_busy: got %b expected 0", memidle); end
    dack = 1'b1;
    #1;
    checks++; if (rdata_ack !== 2'b10) begin errors++; $display("FAIL pp_rdata_ch1: got %b expected 10", rdata_ack); end
    tick;
    dack = 1'b0;
    #1;
    checks++; if (memidle !== 1'b1) begin errors++; $display("FAIL pp_memidle: got %b expected 1", memidle); end
  endtask

  task automatic test_bus_back;
    bus_back = 1'b0; ack = 1'b1; req_wr = 2'b01;
    req_addr[23:0] = 24'h0ABCDE; req_width[3:0] = 4'h2;
    tick;
    req_wr = 2'b00;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (gnt_ack !== 2'b00) begin errors++; $display("FAIL bb_gnt[%0d]: got %b expected 00", i, gnt_ack); end
      checks++; if (bus_oe !== 1'b0) begin errors++; $display("FAIL bb_oe[%0d]: got %b expected 0", i, bus_oe); end
      checks++; if (addr_out !== 24'h0ABCDE) begin errors++; $display("FAIL bb_addr[%0d]: got %h expected 0abcde", i, addr_out); end
      checks++; if (mreq_out !== 1'b1) begin errors++; $display("FAIL bb_mreq[%0d]: got %b expected 1", i, mreq_out); end
      tick;
    end
    bus_back = 1'b1;
    #1;
    checks++; if (gnt_ack !== 2'b01) begin errors++; $display("FAIL bb_gnt_granted: got %b expected 01", gnt_ack); end
    checks++; if (bus_oe !== 1'b1) begin errors++; $display("FAIL bb_oe_granted: got %b expected 1", bus_oe); end
    tick;
    ack = 1'b0;
    #1;
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL bb_idle: got %b expected 0", active); end
  endtask

  task automatic test_reset_mid;
    req_rd = 2'b01;
    tick;
    ack = 1'b1; req_rd = 2'b00; req_wr = 2'b10;
    #1;
    checks++; if (gnt_ack !== 2'b01) begin errors++; $display("FAIL rm_gnt: got %b expected 01", gnt_ack); end
    tick;
    req_wr = 2'b00; ack = 1'b0;
    #1;
    checks++; if (active !== 1'b1) begin errors++; $display("FAIL rm_active: got %b expected 1", active); end
    checks++; if (memidle !== 1'b0) begin errors++; $display("FAIL rm_busy: got %b expected 0", memidle); end
    reset_n = 1'b0;
    #1;
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL rm_active_rst: got %b expected 0", active); end
    checks++; if (mreq_out !== 1'b0) begin errors++; $display("FAIL rm_mreq_rst: got %b expected 0", mreq_out); end
    checks++; if (addr_out !== 24'h0) begin errors++; $display("FAIL rm_addr_rst: got %h expected 0", addr_out); end
    checks++; if (cur_ch !== 1'b0) begin errors++; $display("FAIL rm_ch_rst: got %b expected 0", cur_ch); end
    checks++; if (memidle !== 1'b1) begin errors++; $display("FAIL rm_memidle_rst: got %b expected 1", memidle); end
    tick;
    reset_n = 1'b1; dack = 1'b1;
    #1;
    checks++; if (rdata_ack !== 2'b00) begin errors++; $display("FAIL rm_rdata_after: got %b expected 00", rdata_ack); end
    dack = 1'b0; req_wr = 2'b11;
    tick;
    req_wr = 2'b00;
    #1;
    checks++; if (cur_ch !== 1'b0) begin errors++; $display("FAIL rm_rr_reset: got %b expected 0", cur_ch); end
    ack = 1'b1;
    tick;
    ack = 1'b0;
  endtask

  initial begin
    test_reset;
    test_single_write;
    test_back_to_back;
    test_outstanding;
    test_interleave;
    test_push_pop;
    test_bus_back;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
